weight_loader: RTL and testbench

Writer side of the weight/embedding RAM that the inference FSM reads. Accepts a framed byte stream from the host link (UART RX FIFO) and assembles little-endian 16-bit words. Writes them to consecutive RAM addresses starting at BASE_ADDR over a request/acknowledge write port. Reports completion, checksum error and word count, so inference starts only after a verified load.

---
 rtl/inference_pkg.sv | 24 ++
 rtl/xor_checksum8.sv | 24 ++
 rtl/weight_loader.sv | 172 +++++++++++++++++
 tb/tb_weight_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inference_pkg.sv
// Shared layout constants and loader state encoding for the weight loader and inference FSM.
package inference_pkg;

    localparam logic [7:0]  MAGIC_BYTE     = 8'hA5;
    localparam int unsigned VOCAB_SIZE     = 16;
    localparam int unsigned EMBEDDING_SIZE = 16;
    localparam int unsigned LINEAR_SIZE    = 16;

    // Embedding table, linear weights, then one bias word per linear output.
    localparam int unsigned MODEL_WORDS = VOCAB_SIZE * EMBEDDING_SIZE
                                        + EMBEDDING_SIZE * LINEAR_SIZE
                                        + LINEAR_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_CNT_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_WRITE   = 3'd5,
        ST_CHECK   = 3'd6
    } state_t;

endpackage

// File: rtl/xor_checksum8.sv
// Running 8-bit XOR checksum with synchronous clear.
module xor_checksum8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_data,
    output logic [7:0] o_acc
);

    logic [7:0] r_acc;

    // Accumulate on enable; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_acc <= 8'h00;
        end else if (i_enable) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/weight_loader.sv
// Framed byte stream to 16-bit RAM writes with XOR checksum verification.
module weight_loader
    import inference_pkg::*;
#(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [7:0]  MAGIC     = MAGIC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [15:0]       write_data,
    output logic              write_request,
    input  logic              write_ack,
    output logic              busy,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_written
);

    // The last written word must still be addressable.
    if (64'(BASE_ADDR) + 64'(MAX_WORDS) > (64'(1) << ADDR_W)) begin : g_addr_range_check
        $error("weight_loader: BASE_ADDR + MAX_WORDS exceeds the address space");
    end

    state_t            r_state;
    logic              r_rx_ready;
    logic [ADDR_W-1:0] r_write_address;
    logic [15:0]       r_write_data;
    logic              r_write_request;
    logic              r_busy;
    logic              r_load_done;
    logic              r_load_error;
    logic [15:0]       r_words_written;
    logic [15:0]       r_index;
    logic [15:0]       r_count;
    logic [7:0]        r_lo;

    logic              w_accept;
    logic              w_is_magic;
    logic [15:0]       w_count;
    logic              w_ck_clear;
    logic              w_ck_enable;
    logic [7:0]        w_ck_byte;
    logic [7:0]        w_ck_acc;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_is_magic  = (rx_data == MAGIC);
    assign w_count     = {rx_data, r_count[7:0]};
    assign w_ck_clear  = (r_state == ST_IDLE) && w_accept && w_is_magic;
    assign w_ck_enable = (r_state == ST_DATA_HI) && w_accept;
    assign w_ck_byte   = r_lo ^ rx_data;

    xor_checksum8 u_checksum (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_ck_clear),
        .i_enable (w_ck_enable),
        .i_data   (w_ck_byte),
        .o_acc    (w_ck_acc)
    );

    // Frame parser and write-port FSM; rx_ready is low only while a write is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_rx_ready      <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= 16'h0000;
            r_write_request <= 1'b0;
            r_busy          <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_error    <= 1'b0;
            r_words_written <= 16'h0000;
            r_index         <= 16'h0000;
            r_count         <= 16'h0000;
            r_lo            <= 8'h00;
        end else begin
            r_rx_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_magic) begin
                        r_load_done     <= 1'b0;
                        r_load_error    <= 1'b0;
                        r_words_written <= 16'h0000;
                        r_index         <= 16'h0000;
                        r_busy          <= 1'b1;
                        r_state         <= ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= rx_data;
                        r_state      <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (w_accept) begin
                        r_count <= w_count;
                        if (w_count > 16'(MAX_WORDS)) begin
                            r_load_error <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else if (w_count == 16'h0000) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA_LO;
                        end
                    end
                end
                ST_DATA_LO: begin
                    if (w_accept) begin
                        r_lo    <= rx_data;
                        r_state <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (w_accept) begin
                        r_write_data    <= {rx_data, r_lo};
                        r_write_address <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_index);
                        r_write_request <= 1'b1;
                        r_rx_ready      <= 1'b0;
                        r_state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (write_ack) begin
                        r_write_request <= 1'b0;
                        r_index         <= r_index + 16'd1;
                        r_words_written <= r_words_written + 16'd1;
                        if ((r_index + 16'd1) == r_count) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA_LO;
                        end
                    end else begin
                        r_rx_ready <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        if (rx_data == w_ck_acc) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_load_error <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready      = r_rx_ready;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign write_request = r_write_request;
    assign busy          = r_busy;
    assign load_done     = r_load_done;
    assign load_error    = r_load_error;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: frames in, expected RAM writes checked at each ack.
module tb_weight_loader;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned BASE   = 0;
    localparam int unsigned MAXW   = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] write_address;
    logic [15:0]       write_data;
    logic              write_request;
    logic              write_ack = 1'b0;
    logic              busy;
    logic              load_done;
    logic              load_error;
    logic [15:0]       words_written;

    int n_checks = 0;
    int n_errors = 0;
    int ack_wait = 0;
    int wait_cnt = 0;
    int req_len  = 0;
    int n_writes = 0;

    logic [ADDR_W+15:0] exp_q[$];
    logic [ADDR_W+15:0] held;
    logic [ADDR_W+15:0] exp_entry;
    logic [15:0]        word_buf [16];

    always #5 clk = ~clk;

    weight_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .MAGIC     (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_request (write_request),
        .write_ack     (write_ack),
        .busy          (busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_written (words_written)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // RAM responder: acks after ack_wait stall cycles and checks each accepted write.
    always @(negedge clk) begin
        if (write_request === 1'b1) begin
            if (req_len == 0) held = {write_address, write_data};
            req_len++;
            check("rx_ready_in_write", 64'(rx_ready), 64'(0));
            if (wait_cnt >= ack_wait) begin
                write_ack = 1'b1;
                check("wr_stable", 64'({write_address, write_data}), 64'(held));
                check("wr_len", 64'(req_len), 64'(ack_wait + 1));
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    exp_entry = exp_q.pop_front();
                    check("wr_addr_data", 64'({write_address, write_data}), 64'(exp_entry));
                end
                n_writes++;
            end else begin
                write_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            write_ack = 1'b0;
            wait_cnt  = 0;
            req_len   = 0;
        end
    end

    // Present one byte and return at the negedge after its handshake; rx_valid stays high.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_timeout", 64'(n), 64'(0));
        @(negedge clk);
    endtask

    // Send a frame of cnt words from word_buf; checksum is the XOR of the data bytes.
    task automatic send_frame(input int cnt, input bit corrupt);
        logic [7:0]  chk;
        logic [15:0] c16;
        chk = 8'h00;
        c16 = 16'(cnt);
        send_byte(8'hA5);
        send_byte(c16[7:0]);
        send_byte(c16[15:8]);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({ADDR_W'(BASE + i), word_buf[i]});
            chk = chk ^ word_buf[i][7:0] ^ word_buf[i][15:8];
            send_byte(word_buf[i][7:0]);
            send_byte(word_buf[i][15:8]);
        end
        send_byte(corrupt ? ~chk : chk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string phase);
        check({phase, "_rx_ready"}, 64'(rx_ready), 64'(0));
        check({phase, "_write_request"}, 64'(write_request), 64'(0));
        check({phase, "_write_address"}, 64'(write_address), 64'(0));
        check({phase, "_write_data"}, 64'(write_data), 64'(0));
        check({phase, "_busy"}, 64'(busy), 64'(0));
        check({phase, "_load_done"}, 64'(load_done), 64'(0));
        check({phase, "_load_error"}, 64'(load_error), 64'(0));
        check({phase, "_words_written"}, 64'(words_written), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // Two-word good frame.
        word_buf[0] = 16'h1234;
        word_buf[1] = 16'h5678;
        send_frame(2, 1'b0);
        check("t1_done", 64'(load_done), 64'(1));
        check("t1_error", 64'(load_error), 64'(0));
        check("t1_words", 64'(words_written), 64'(2));
        check("t1_busy", 64'(busy), 64'(0));

        // Same frame with a bad checksum: words still written.
        send_frame(2, 1'b1);
        check("t2_done", 64'(load_done), 64'(0));
        check("t2_error", 64'(load_error), 64'(1));
        check("t2_words", 64'(words_written), 64'(2));

        // Garbage before an empty frame.
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        check("t3_garbage_busy", 64'(busy), 64'(0));
        send_frame(0, 1'b0);
        check("t3_done", 64'(load_done), 64'(1));
        check("t3_error", 64'(load_error), 64'(0));
        check("t3_words", 64'(words_written), 64'(0));
        check("t3_no_writes", 64'(n_writes), 64'(w0));

        // Oversize count 0x0401.
        w0 = n_writes;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        rx_valid = 1'b0;
        check("t4_error", 64'(load_error), 64'(1));
        check("t4_done", 64'(load_done), 64'(0));
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_wreq", 64'(write_request), 64'(0));
        repeat (4) @(negedge clk);
        check("t4_no_writes", 64'(n_writes), 64'(w0));

        // Slow RAM: ack in the fifth request cycle, bytes held upstream meanwhile.
        ack_wait = 4;
        for (int i = 0; i < 3; i++) word_buf[i] = 16'($urandom);
        send_frame(3, 1'b0);
        check("t5_done", 64'(load_done), 64'(1));
        check("t5_words", 64'(words_written), 64'(3));
        ack_wait = 0;

        // Reset during the second write of a four-word frame.
        for (int i = 0; i < 4; i++) word_buf[i] = 16'($urandom);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        exp_q.push_back({ADDR_W'(BASE), word_buf[0]});
        send_byte(word_buf[0][7:0]);
        send_byte(word_buf[0][15:8]);
        send_byte(word_buf[1][7:0]);
        ack_wait = 100;
        send_byte(word_buf[1][15:8]);
        rx_valid = 1'b0;
        check("t6_wreq_pending", 64'(write_request), 64'(1));
        check("t6_addr_pending", 64'(write_address), 64'(BASE + 1));
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t6");
        reset = 1'b0;
        ack_wait = 0;
        @(negedge clk);

        // Good frame after reset, with magic bytes inside the data.
        word_buf[0] = 16'h00A5;
        word_buf[1] = 16'hA5A5;
        word_buf[2] = 16'h1234;
        send_frame(3, 1'b0);
        check("t7_done", 64'(load_done), 64'(1));
        check("t7_error", 64'(load_error), 64'(0));
        check("t7_words", 64'(words_written), 64'(3));

        repeat (4) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
